// File: rtl/fpu_vector_sequencer.sv
// On-chip FPU test-vector engine: issues preloaded vectors to a pipelined FPU and
// checks each result LATENCY cycles later against stored expected value/flags.
module fpu_vector_sequencer #(
  parameter int unsigned        WIDTH     = 32,
  parameter int unsigned        OP_W      = 3,
  parameter int unsigned        RMODE_W   = 2,
  parameter int unsigned        FLAG_W    = 8,
  parameter int unsigned        DEPTH     = 64,
  parameter int unsigned        LATENCY   = 4,
  parameter logic [FLAG_W-1:0]  FLAG_MASK = '1,
  localparam int unsigned       AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_we,
  input  logic [AW-1:0]      ld_addr,
  input  logic [WIDTH-1:0]   ld_a,
  input  logic [WIDTH-1:0]   ld_b,
  input  logic [OP_W-1:0]    ld_op,
  input  logic [WIDTH-1:0]   ld_exp,
  input  logic [FLAG_W-1:0]  ld_exp_flags,
  input  logic               start,
  input  logic [AW:0]        num_vec,
  input  logic [RMODE_W-1:0] rmode,
  input  logic [3:0]         gap,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic [OP_W-1:0]    dut_op,
  output logic [RMODE_W-1:0] dut_rmode,
  input  logic [WIDTH-1:0]   dut_out,
  input  logic [FLAG_W-1:0]  dut_flags,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [AW:0]        err_count,
  output logic               first_err_vld,
  output logic [AW-1:0]      first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     last_idx;
  logic [3:0]        gap_q;
  logic [3:0]        gap_cnt;

  logic [WIDTH-1:0]  ram_a     [DEPTH];
  logic [WIDTH-1:0]  ram_b     [DEPTH];
  logic [OP_W-1:0]   ram_op    [DEPTH];
  logic [WIDTH-1:0]  ram_exp   [DEPTH];
  logic [FLAG_W-1:0] ram_flags [DEPTH];

  // Check pipe: stage 0 is loaded together with dut_*, stage LATENCY lines up with dut_out.
  logic [LATENCY:0]  pv;
  logic [AW-1:0]     pidx [LATENCY+1];
  logic [WIDTH-1:0]  pexp [LATENCY+1];
  logic [FLAG_W-1:0] pflg [LATENCY+1];

  logic              running_c;
  logic              issue_c;
  logic              mism_c;
  logic [AW:0]       nv_c;

  assign running_c = (state == S_ISSUE) || (state == S_DRAIN);
  assign issue_c   = (state == S_ISSUE) && (gap_cnt == 4'd0);
  assign mism_c    = pv[LATENCY] &&
                     ((dut_out != pexp[LATENCY]) ||
                      (((dut_flags ^ pflg[LATENCY]) & FLAG_MASK) != '0));
  assign nv_c      = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;

  // Vector RAM write port; loads are dropped while a run is in progress.
  always_ff @(posedge clk) begin
    if (ld_we && !running_c) begin
      ram_a[ld_addr]     <= ld_a;
      ram_b[ld_addr]     <= ld_b;
      ram_op[ld_addr]    <= ld_op;
      ram_exp[ld_addr]   <= ld_exp;
      ram_flags[ld_addr] <= ld_exp_flags;
    end
  end

  always_ff @(posedge clk) begin
    pidx[0] <= idx;
    pexp[0] <= ram_exp[idx];
    pflg[0] <= ram_flags[idx];
    for (int i = 1; i <= LATENCY; i++) begin
      pidx[i] <= pidx[i-1];
      pexp[i] <= pexp[i-1];
      pflg[i] <= pflg[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      last_idx      <= '0;
      gap_q         <= '0;
      gap_cnt       <= '0;
      pv            <= '0;
      dut_a         <= '0;
      dut_b         <= '0;
      dut_op        <= '0;
      dut_rmode     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      pv <= {pv[LATENCY-1:0], issue_c};
      if (mism_c) begin
        if (err_count != '1) err_count <= err_count + (AW+1)'(1);
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= pidx[LATENCY];
        end
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            dut_rmode     <= rmode;
            gap_q         <= gap;
            gap_cnt       <= gap;
            idx           <= '0;
            last_idx      <= AW'(nv_c - (AW+1)'(1));
            if (num_vec == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_ISSUE;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else begin
            dut_a   <= ram_a[idx];
            dut_b   <= ram_b[idx];
            dut_op  <= ram_op[idx];
            gap_cnt <= gap_q;
            idx     <= idx + AW'(1);
            if (idx == last_idx) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finish on the edge that checks the final entry.
          if (pv[LATENCY-1:0] == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mism_c && (err_count == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_vector_sequencer.sv
// Directed bench for fpu_vector_sequencer with a 4-cycle reference FPU model; two
// instances share stimulus, one with the full flag mask and one ignoring the inf flag.
module tb_fpu_vector_sequencer;

  localparam int unsigned AW = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [5:0]  ld_addr;
  logic [31:0] ld_a, ld_b, ld_exp;
  logic [2:0]  ld_op;
  logic [7:0]  ld_exp_flags;
  logic        start;
  logic [6:0]  num_vec;
  logic [1:0]  rmode;
  logic [3:0]  gap;
  logic [31:0] dut_out;
  logic [7:0]  dut_flags;

  logic [31:0] dut_a, dut_b;
  logic [2:0]  dut_op;
  logic [1:0]  dut_rmode;
  logic        busy, done, pass, first_err_vld;
  logic [6:0]  err_count;
  logic [5:0]  first_err_idx;

  logic [31:0] dut_a_m, dut_b_m;
  logic [2:0]  dut_op_m;
  logic [1:0]  dut_rmode_m;
  logic        busy_m, done_m, pass_m, first_err_vld_m;
  logic [6:0]  err_count_m;
  logic [5:0]  first_err_idx_m;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit busy_seen;

  always #5 clk = ~clk;

  fpu_vector_sequencer #(.LATENCY(4), .FLAG_MASK(8'hFF)) u_dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
    .ld_op(ld_op), .ld_exp(ld_exp), .ld_exp_flags(ld_exp_flags), .start(start),
    .num_vec(num_vec), .rmode(rmode), .gap(gap), .dut_a(dut_a), .dut_b(dut_b),
    .dut_op(dut_op), .dut_rmode(dut_rmode), .dut_out(dut_out), .dut_flags(dut_flags),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vld(first_err_vld), .first_err_idx(first_err_idx));

  fpu_vector_sequencer #(.LATENCY(4), .FLAG_MASK(8'h7F)) u_dut_m (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
    .ld_op(ld_op), .ld_exp(ld_exp), .ld_exp_flags(ld_exp_flags), .start(start),
    .num_vec(num_vec), .rmode(rmode), .gap(gap), .dut_a(dut_a_m), .dut_b(dut_b_m),
    .dut_op(dut_op_m), .dut_rmode(dut_rmode_m), .dut_out(dut_out), .dut_flags(dut_flags),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_count_m),
    .first_err_vld(first_err_vld_m), .first_err_idx(first_err_idx_m));

  // Reference FPU: op0 add (known cases), op1 mul (overflow case), op2 pass-through of a.
  function automatic logic [39:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? {32'h4040_0000, 8'h00}
                                                               : {32'h7FC0_0000, 8'h20};
      3'd1: return (a == 32'h7F00_0000 && b == 32'h7F00_0000) ? {32'h7F80_0000, 8'h88}
                                                               : {a, 8'h00};
      default: return {a, 8'h00};
    endcase
  endfunction

  logic [39:0] fpipe [4];
  always @(posedge clk) begin
    fpipe[0] <= fpu_ref(dut_a, dut_b, dut_op);
    fpipe[1] <= fpipe[0];
    fpipe[2] <= fpipe[1];
    fpipe[3] <= fpipe[2];
  end
  assign dut_out   = fpipe[3][39:8];
  assign dut_flags = fpipe[3][7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [31:0] e, input logic [7:0] f);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 6'(addr); ld_a = a; ld_b = b; ld_op = op;
    ld_exp = e; ld_exp_flags = f;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Pulse start and count negedges until done (0 = done visible right after the start edge).
  task automatic run(input logic [6:0] n, input logic [3:0] g, output int c, output bit bs);
    @(negedge clk);
    num_vec = n; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    bs = busy;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      bs |= busy;
    end
  endtask

  initial begin
    rst = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_a = '0; ld_b = '0; ld_op = '0;
    ld_exp = '0; ld_exp_flags = '0; start = 1'b0; num_vec = '0; rmode = '0; gap = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_dut_a", dut_a, 0);
    chk("rst_rmode", dut_rmode, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: 0..3 = 1.0+2.0, 4 = overflow multiply (exp omits inf flag), 5..63 = pass-through.
    for (int i = 0; i < 4; i++) load(i, 32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 8'h00);
    load(4, 32'h7F00_0000, 32'h7F00_0000, 3'd1, 32'h7F80_0000, 8'h08);
    for (int i = 5; i < 64; i++) load(i, 32'(i), 32'd0, 3'd2, 32'(i), 8'h00);

    rmode = 2'd2;
    run(7'd4, 4'd0, cyc, busy_seen);
    chk("t1_cycles", cyc, 9);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_fev", first_err_vld, 0);
    chk("t1_rmode", dut_rmode, 2);
    chk("t1_busy_after", busy, 0);
    chk("t1_dut_a_hold", dut_a, 32'h3F80_0000);

    load(2, 32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h4040_0001, 8'h00);
    run(7'd4, 4'd0, cyc, busy_seen);
    chk("t2_cycles", cyc, 9);
    chk("t2_pass", pass, 0);
    chk("t2_err", err_count, 1);
    chk("t2_fev", first_err_vld, 1);
    chk("t2_fei", first_err_idx, 2);

    load(2, 32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 8'h00);
    run(7'd5, 4'd0, cyc, busy_seen);
    chk("t3_cycles", cyc, 10);
    chk("t3_err_full", err_count, 1);
    chk("t3_fei_full", first_err_idx, 4);
    chk("t3_pass_full", pass, 0);
    chk("t3_pass_mask", pass_m, 1);
    chk("t3_err_mask", err_count_m, 0);

    run(7'd0, 4'd0, cyc, busy_seen);
    chk("t4_cycles", cyc, 0);
    chk("t4_pass", pass, 1);
    chk("t4_busy_seen", 32'(busy_seen), 0);
    chk("t4_err_cleared", err_count, 0);

    run(7'd69, 4'd0, cyc, busy_seen);
    chk("t5_cycles", cyc, 69);
    chk("t5_last_a", dut_a, 63);
    chk("t5_err", err_count, 1);
    chk("t5_fei", first_err_idx, 4);
    chk("t5_pass_mask", pass_m, 1);

    for (int i = 0; i < 3; i++) load(i, 32'(100 + i), 32'd0, 3'd2, 32'(100 + i), 8'h00);
    @(negedge clk);
    num_vec = 7'd3; gap = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 40 && cyc < 0; k++) begin
      if (k == 2) begin
        start = 1'b1; ld_we = 1'b1; ld_addr = 6'd0; ld_a = 32'd999; ld_exp = 32'd999;
      end else begin
        start = 1'b0; ld_we = 1'b0;
      end
      @(negedge clk);
      if (k == 3)  chk("t6_a_hold_before", dut_a, 63);
      if (k == 4)  chk("t6_a_issue0", dut_a, 100);
      if (k == 7)  chk("t6_a_gap", dut_a, 100);
      if (k == 8)  chk("t6_a_issue1", dut_a, 101);
      if (k == 12) chk("t6_a_issue2", dut_a, 102);
      if (done) cyc = k;
    end
    start = 1'b0; ld_we = 1'b0;
    chk("t6_cycles", cyc, 17);
    chk("t6_pass", pass, 1);
    run(7'd1, 4'd0, cyc, busy_seen);
    chk("t6_ram_intact_a", dut_a, 100);
    chk("t6_ram_intact_pass", pass, 1);
    chk("t6_ram_cycles", cyc, 6);

    @(negedge clk);
    num_vec = 7'd4; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t7_busy_mid", busy, 1);
    rst = 1'b1;
    #1;
    chk("t7_abort_busy", busy, 0);
    chk("t7_abort_done", done, 0);
    chk("t7_abort_dut_a", dut_a, 0);
    chk("t7_abort_rmode", dut_rmode, 0);
    chk("t7_abort_pass", pass, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("t7_start_in_rst", busy, 0);
    run(7'd3, 4'd0, cyc, busy_seen);
    chk("t7_rerun_cycles", cyc, 8);
    chk("t7_rerun_pass", pass, 1);
    chk("t7_rerun_a", dut_a, 102);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
